dcache_read_arbiter: RTL and testbench
======================================

// Module: dcache_read_arbiter
// PURPOSE
//  Shares the single data-cache read port among NUM_REQ load requesters
//  (load reservation stations, store-address checks).
//  Sits between the load units and the dCache; requesters never drive
//  dCache_readPtr directly.
//  Round-robin grant, skipping requesters whose target cache block is flagged busy.
//  Returns the read value to the granted requester with a one-hot response strobe.
// PARAMETERS
//  NUM_REQ                        4   number of requesters (>=2)
//  NUM_REQ_LOG                    2   clog2(NUM_REQ)
//  NUMBER_OF_BLOCKS_IN_CACHE      4   width of dCache_busy
//  NUMBER_OF_BLOCKS_IN_CACHE_LOG  2   block-index width
//  BLOCK_SIZE_LOG                 4   block index = addr[BLOCK_SIZE_LOG +: NUMBER_OF_BLOCKS_IN_CACHE_LOG]
//  TIMEOUT                        64  max cycles waiting for dCache_readSuccess
// PORTS
//  clk                clk  in   1            rising-edge clock
//  reset              in   1                 synchronous, active-high reset
//  req_valid          in   NUM_REQ           request pending, per requester
//  req_addr           in   NUM_REQ*32        byte address; requester i uses bits [32*i +: 32]
//  req_ready          out  NUM_REQ           one-cycle one-hot accept pulse
//  resp_valid         out  NUM_REQ           one-cycle one-hot response strobe
//  resp_data          out  32                read value, valid while resp_valid != 0
//  resp_err           out  1                 with resp_valid: request timed out, resp_data = 0
//  flush              in   1                 pipeline flush (mispredict); in-flight result discarded
//  dCache_readPtr     out  32                read address to cache
//  dCache_readReq     out  1                 read request level to cache
//  dCache_readValue   in   32                cache read data
//  dCache_readSuccess in   1                 cache read done; sampled on clk
//  dCache_busy        in   NUMBER_OF_BLOCKS_IN_CACHE   per-block busy flags
// BEHAVIOUR
//  - All state updates on posedge clk; reset is synchronous, active-high.
//  - Reset (also mid-operation): state=IDLE, rr_ptr=0, cnt=0, discard=0.
//    Outputs: req_ready=0, resp_valid=0, resp_data=0, resp_err=0,
//    dCache_readReq=0, dCache_readPtr=0. Any in-flight read is dropped, no response.
//  - Eligible(i) = req_valid[i] && !dCache_busy[blk(req_addr_i)].
//  - Handshake: requester holds req_valid/req_addr stable until its req_ready pulse.
//    It may drop req_valid afterwards. Non-granted requesters keep waiting.
//  - FSM:
//    IDLE: if any eligible, owner = first eligible at or after rr_ptr (cyclic).
//      Latch addr, pulse req_ready[owner], -> READ. Else stay.
//    READ: dCache_readReq=1, dCache_readPtr=latched addr; cnt increments.
//      If dCache_readSuccess: latch dCache_readValue -> RESP.
//      Else if cnt==TIMEOUT-1: -> RESP with err=1.
//      Success and timeout in the same cycle: success wins.
//    RESP: dCache_readReq=0. resp_valid[owner]=1, resp_data, resp_err for one cycle,
//      unless discard=1 (then no strobe).
//      rr_ptr=(owner+1) mod NUM_REQ, cnt=0, discard=0 -> IDLE.
//  - flush: in IDLE it is ignored. In READ it sets discard; the cache read still
//    completes (or times out) so the cache is not left mid-access.
//    In RESP it suppresses the strobe.
//  - Latency: grant at cycle T; readReq high from T+1; success sampled at T+1+k;
//    resp_valid at T+2+k. Minimum 3 cycles grant-to-response.
//  - Throughput: one read in flight; next grant no earlier than the cycle after RESP.
//  - A requester may be re-granted in the IDLE cycle right after its own RESP
//    only if no other eligible requester is ahead in round-robin order.
//  - dCache_busy is sampled only in IDLE. A block going busy after grant does not
//    abort the read.
//  - All-ineligible (all busy or no valid): stay IDLE, no pulses.
// TESTING
//  1 Single req: req_valid=0001, addr0=0x20, cache returns 0xDEADBEEF 2 cycles after readReq
//    -> req_ready=0001 at T; readPtr=0x20; resp_valid=0001 with 0xDEADBEEF at T+4.
//  2 Fairness: req_valid=1111 held, zero-wait cache
//    -> grants in order 0,1,2,3,0 (one per 3 cycles), no starvation.
//  3 Busy skip: addr0=0x10 (blk1), addr1=0x20 (blk2), dCache_busy=0010
//    -> requester 1 granted first; requester 0 granted after busy clears.
//  4 Timeout: readSuccess never asserted
//    -> readReq high exactly 64 cycles, then resp_valid=owner, resp_err=1, resp_data=0.
//  5 Flush: flush pulse 1 cycle after grant
//    -> readReq held until success, no resp_valid, next grant proceeds normally.
//  6 Reset mid-READ: reset asserted while readReq=1
//    -> next cycle all outputs 0; no response; rr restarts at requester 0.

Source files
------------

// File: rtl/dcache_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dcache_read_arbiter
// Brief    : Round-robin sharing of the single dCache read port among load
//            requesters, skipping requesters whose target block is busy.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_read_arbiter #(
  parameter int NUM_REQ                       = 4,
  parameter int NUM_REQ_LOG                   = 2,
  parameter int NUMBER_OF_BLOCKS_IN_CACHE     = 4,
  parameter int NUMBER_OF_BLOCKS_IN_CACHE_LOG = 2,
  parameter int BLOCK_SIZE_LOG                = 4,
  parameter int TIMEOUT                       = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*32-1:0]                req_addr,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   resp_valid,
  output logic [31:0]                          resp_data,
  output logic                                 resp_err,
  input  logic                                 flush,
  output logic [31:0]                          dCache_readPtr,
  output logic                                 dCache_readReq,
  input  logic [31:0]                          dCache_readValue,
  input  logic                                 dCache_readSuccess,
  input  logic [NUMBER_OF_BLOCKS_IN_CACHE-1:0] dCache_busy
);

  localparam int                    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_REQ_LOG-1:0] LAST_REQ = NUM_REQ_LOG'(NUM_REQ - 1);
  localparam logic [NUM_REQ_LOG:0]  NUM_REQ_W = (NUM_REQ_LOG + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_REQ_LOG-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ_LOG-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     discard_q, discard_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic                     err_q, err_d;

  logic [NUM_REQ-1:0]       eligible;
  logic                     grant_found;
  logic [NUM_REQ_LOG-1:0]   grant_idx;
  logic [31:0]              grant_addr;
  logic [NUM_REQ_LOG:0]     cand;
  logic                     resp_fire;

  // A requester competes only if the cache block its address maps to is idle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      logic [NUMBER_OF_BLOCKS_IN_CACHE_LOG-1:0] blk;
      assign blk          = req_addr[32*gi + BLOCK_SIZE_LOG +: NUMBER_OF_BLOCKS_IN_CACHE_LOG];
      assign eligible[gi] = req_valid[gi] && !dCache_busy[blk];
    end
  endgenerate

  // First eligible requester at or after rr_ptr, scanning cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (NUM_REQ_LOG + 1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!grant_found && eligible[cand[NUM_REQ_LOG-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[NUM_REQ_LOG-1:0];
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == NUM_REQ_LOG'(i)) begin
        grant_addr = req_addr[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          owner_d   = grant_idx;
          addr_d    = grant_addr;
          cnt_d     = '0;
          discard_d = 1'b0;
          err_d     = 1'b0;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 1'b1;
        // A flushed read still runs to completion so the cache never sees an aborted access.
        if (flush) begin
          discard_d = 1'b1;
        end
        if (dCache_readSuccess) begin
          data_d  = dCache_readValue;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d  = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
        cnt_d     = '0;
        discard_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign resp_fire = (state_q == ST_RESP) && !discard_q && !flush;

  always_comb begin
    req_ready      = '0;
    resp_valid     = '0;
    resp_data      = '0;
    resp_err       = 1'b0;
    dCache_readReq = (state_q == ST_READ);
    dCache_readPtr = addr_q;
    if ((state_q == ST_IDLE) && grant_found) begin
      req_ready = NUM_REQ'(1) << grant_idx;
    end
    if (resp_fire) begin
      resp_valid = NUM_REQ'(1) << owner_q;
      resp_data  = data_q;
      resp_err   = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_read_arbiter
// Brief    : Transaction-level model plus scoreboard for dcache_read_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_read_arbiter;

  localparam int N   = 4;
  localparam int NL  = 2;
  localparam int NB  = 4;
  localparam int NBL = 2;
  localparam int BSL = 4;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic            flush = 1'b0;
  logic [31:0]     dCache_readPtr;
  logic            dCache_readReq;
  logic [31:0]     dCache_readValue = '0;
  logic            dCache_readSuccess = 1'b0;
  logic [NB-1:0]   dCache_busy = '0;

  always #5 clk = ~clk;

  dcache_read_arbiter #(
    .NUM_REQ(N), .NUM_REQ_LOG(NL), .NUMBER_OF_BLOCKS_IN_CACHE(NB),
    .NUMBER_OF_BLOCKS_IN_CACHE_LOG(NBL), .BLOCK_SIZE_LOG(BSL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .flush(flush), .dCache_readPtr(dCache_readPtr),
    .dCache_readReq(dCache_readReq), .dCache_readValue(dCache_readValue),
    .dCache_readSuccess(dCache_readSuccess), .dCache_busy(dCache_busy)
  );

  typedef struct { int cyc; int owner; } grant_t;
  typedef struct { int cyc; int owner; logic [31:0] data; logic err; } resp_t;
  grant_t gq[$];
  resp_t  rq[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Requester and transaction-level arbiter model
  bit [N-1:0]  pend = '0;
  logic [31:0] paddr [N];
  int          rr = 0, free_at = 0, last_grant = -1;
  bit          act = 0;
  int          t_owner = 0, t_grant = 0, t_succ = -1, t_resp = 0;
  logic [31:0] t_data = '0, t_addr = '0;
  bit          t_err = 0, t_disc = 0;
  bit          exp_rdreq = 0, zero_chk = 0, zero_next = 0;
  logic [31:0] exp_ptr = '0;

  // Stimulus knobs
  bit          rand_mode = 0, hold_all = 0, reset_knob = 1, flush_on_grant = 0;
  bit          use_fdata = 0;
  int          force_lat = -1;
  logic [31:0] fdata = '0;
  logic [NB-1:0] busy_knob = '0;

  function automatic logic [31:0] onehot(input int i);
    return 32'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
  endtask

  task automatic step();
    int own, idx, lat;
    logic [NBL-1:0] blk;
    @(posedge clk);
    #1;
    cyc++;
    if (last_grant >= 0) begin
      if (!hold_all) pend[last_grant] = 1'b0;
      last_grant = -1;
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = pend[i];
      req_addr[32*i +: 32] = paddr[i];
    end
    dCache_busy = rand_mode ? (($urandom_range(0, 2) == 0) ? NB'($urandom) : '0) : busy_knob;
    flush = (rand_mode && $urandom_range(0, 15) == 0) ||
            (act && flush_on_grant && cyc == t_grant + 1);
    reset = reset_knob;
    dCache_readSuccess = act && (cyc == t_succ);
    dCache_readValue   = dCache_readSuccess ? t_data : $urandom;
    exp_rdreq = act && (cyc > t_grant) && (cyc < t_resp);
    exp_ptr   = t_addr;
    zero_chk  = 0;
    if (reset) begin
      act       = 0;
      rr        = 0;
      free_at   = cyc + 1;
      zero_next = 1;
    end else begin
      zero_chk  = zero_next;
      zero_next = 0;
      if (act) begin
        if (flush && cyc > t_grant) t_disc = 1;
        if (cyc == t_resp) begin
          if (!t_disc) rq.push_back('{cyc, t_owner, t_err ? 32'h0 : t_data, t_err});
          rr      = (t_owner + 1) % N;
          act     = 0;
          free_at = cyc + 1;
        end
      end else if (cyc >= free_at) begin
        own = -1;
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          blk = paddr[idx][BSL +: NBL];
          if (own < 0 && pend[idx] && !dCache_busy[blk]) own = idx;
        end
        if (own >= 0) begin
          gq.push_back('{cyc, own});
          lat = force_lat;
          if (lat < 0) begin
            lat = $urandom_range(0, 39);
            lat = (lat == 0) ? TO : lat % 4;
          end
          act     = 1;
          t_owner = own;
          t_grant = cyc;
          t_addr  = paddr[own];
          t_data  = use_fdata ? fdata : $urandom;
          t_disc  = 0;
          t_err   = (lat >= TO);
          t_succ  = t_err ? -1 : cyc + 1 + lat;
          t_resp  = t_err ? cyc + 1 + TO : cyc + 2 + lat;
          last_grant = own;
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((act || pend != '0 || cyc < free_at) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("drain_bound", 32'd1, 32'd0);
  endtask

  // Scoreboard monitor: pops expectations when the DUT presents a strobe.
  always @(negedge clk) begin : mon
    grant_t g;
    resp_t  r;
    if (!reset) begin
      if (req_ready != '0) begin
        if (gq.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'd0);
        else begin
          g = gq.pop_front();
          chk("grant_owner", 32'(req_ready), onehot(g.owner));
          chk("grant_cycle", cyc, g.cyc);
        end
      end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
        g = gq.pop_front();
        chk("grant_missing", 32'(req_ready), onehot(g.owner));
      end
      if (resp_valid != '0) begin
        if (rq.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          r = rq.pop_front();
          chk("resp_owner", 32'(resp_valid), onehot(r.owner));
          chk("resp_data", resp_data, r.data);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_cycle", cyc, r.cyc);
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        r = rq.pop_front();
        chk("resp_missing", 32'(resp_valid), onehot(r.owner));
      end
      chk("read_req", 32'(dCache_readReq), 32'(exp_rdreq));
      if (exp_rdreq) chk("read_ptr", dCache_readPtr, exp_ptr);
      if (zero_chk) begin
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_read_ptr", dCache_readPtr, 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) paddr[i] = '0;
    repeat (3) step();
    reset_knob = 0;
    step();

    // Single request, data two cycles after readReq
    pend[0] = 1; paddr[0] = 32'h20; force_lat = 2; use_fdata = 1; fdata = 32'hDEADBEEF;
    drain();
    use_fdata = 0;

    // Fairness with a zero-wait cache
    hold_all = 1; force_lat = 0;
    for (int i = 0; i < N; i++) begin pend[i] = 1; paddr[i] = 32'h100 * (i + 1); end
    repeat (16) step();
    hold_all = 0;
    drain();

    // Busy block is skipped until it clears
    force_lat = 1; busy_knob = 4'b0010;
    pend[0] = 1; paddr[0] = 32'h10; pend[1] = 1; paddr[1] = 32'h20;
    repeat (10) step();
    busy_knob = '0;
    drain();

    // Timeout, then success on the last counted cycle
    force_lat = TO; pend[3] = 1; paddr[3] = 32'h3C0;
    drain();
    force_lat = TO - 1; pend[2] = 1; paddr[2] = 32'h2A0;
    drain();

    // Flush one cycle after grant discards the result
    force_lat = 2; flush_on_grant = 1; pend[1] = 1; paddr[1] = 32'h1B0;
    drain();
    flush_on_grant = 0; pend[0] = 1; paddr[0] = 32'h30;
    drain();

    // Randomized traffic
    force_lat = -1; rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    drain();

    // Reset in the middle of a read; round-robin restarts at requester 0
    force_lat = 1; pend[1] = 1; paddr[1] = 32'h140;
    drain();
    force_lat = 20; pend[2] = 1; paddr[2] = 32'h250;
    for (int n = 0; n < 20 && !act; n++) step();
    step();
    step();
    pend = '0; reset_knob = 1;
    step();
    reset_knob = 0;
    step();
    hold_all = 1; force_lat = 0; pend = '1;
    repeat (4) step();
    hold_all = 0;
    drain();
    repeat (3) step();

    chk("grant_queue_empty", gq.size(), 32'd0);
    chk("resp_queue_empty", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
